// File: rtl/request_unit_mc.sv
// Multi-channel data request unit. Each channel latches a datapath read or
// write on an instruction hit and holds it toward the cache until that
// channel's data hit. Shared logic gates PC advance, counts the cycles of
// the current pending window, aborts overlong windows (sticky flag) and
// honours a global flush.
module request_unit_mc #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic [NCH-1:0]   dhit,
    input  logic [NCH-1:0]   dREN,
    input  logic [NCH-1:0]   dWEN,
    input  logic             flush,
    output logic [NCH-1:0]   dmemREN,
    output logic [NCH-1:0]   dmemWEN,
    output logic             pcen,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    // Counter value on which a still-pending window is aborted.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_MAX - 1);

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [NCH-1:0]   ren_q, ren_d;
    logic [NCH-1:0]   wen_q, wen_d;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             busy_d;
    logic             tmo_abort;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Decode pending channels, the abort condition and the PC enable.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = (state_q[i] == PEND);
        end
        busy = |pend;
        // Abort only if some pending channel is not being completed now.
        tmo_abort = busy && (cnt_q == TMO_LAST) && !flush && (|(pend & ~dhit));
        // PC may advance only when every channel is idle or finishing now;
        // held low while reset is asserted.
        pcen = ihit && !RST && (&(~pend | dhit));
    end

    // Per-channel next state with priority flush > abort > dhit > ihit > hold.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            ren_d[i]   = ren_q[i];
            wen_d[i]   = wen_q[i];
            if (flush || tmo_abort) begin
                state_d[i] = IDLE;
                ren_d[i]   = 1'b0;
                wen_d[i]   = 1'b0;
            end else if (state_q[i] == PEND) begin
                if (dhit[i]) begin
                    state_d[i] = IDLE;
                    ren_d[i]   = 1'b0;
                    wen_d[i]   = 1'b0;
                end
            end else if (ihit && !dhit[i] && (dREN[i] || dWEN[i])) begin
                // A simultaneous read and write request resolves to the write.
                state_d[i] = PEND;
                ren_d[i]   = dREN[i] & ~dWEN[i];
                wen_d[i]   = dWEN[i];
            end
            pend_d[i] = (state_d[i] == PEND);
        end
        busy_d = |pend_d;
    end

    // Stall counter and sticky timeout flag.
    always_comb begin
        cnt_d = '0;
        tmo_d = tmo_q;
        // Count only while a window continues; a fresh window starts at zero.
        if (!flush && !tmo_abort && busy_d && busy) begin
            cnt_d = sat_inc(cnt_q);
        end
        if (flush) begin
            tmo_d = 1'b0;
        end else if (tmo_abort) begin
            tmo_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
            end
            ren_q <= '0;
            wen_q <= '0;
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
            ren_q <= ren_d;
            wen_q <= wen_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign dmemREN   = ren_q;
    assign dmemWEN   = wen_q;
    assign timeout   = tmo_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_request_unit_mc.sv
// Bench for request_unit_mc with NCH=2, CNT_W=8, TMO_MAX=5. Each vector
// carries inputs, the expected combinational pcen for that cycle and the
// expected registered outputs after the following rising edge.
module tb_request_unit_mc;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;

    typedef struct {
        logic             rst;
        logic             ihit;
        logic [NCH-1:0]   dhit;
        logic [NCH-1:0]   dren;
        logic [NCH-1:0]   dwen;
        logic             flush;
        logic             pcen;
        logic [NCH-1:0]   ren;
        logic [NCH-1:0]   wen;
        logic             busy;
        logic [CNT_W-1:0] cnt;
        logic             tmo;
    } vec_t;

    logic             CLK;
    logic             RST;
    logic             ihit;
    logic [NCH-1:0]   dhit;
    logic [NCH-1:0]   dREN;
    logic [NCH-1:0]   dWEN;
    logic             flush;
    logic [NCH-1:0]   dmemREN;
    logic [NCH-1:0]   dmemWEN;
    logic             pcen;
    logic             busy;
    logic             timeout;
    logic [CNT_W-1:0] stall_cnt;

    int   n_vec;
    int   n_err;
    vec_t tbl [$];
    vec_t exp_q [$];

    request_unit_mc #(
        .NCH    (NCH),
        .CNT_W  (CNT_W),
        .TMO_MAX(5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ihit     (ihit),
        .dhit     (dhit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .flush    (flush),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .pcen     (pcen),
        .busy     (busy),
        .timeout  (timeout),
        .stall_cnt(stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input int rst, input int ih, input int dh,
                                input int dr, input int dw, input int fl,
                                input int pc, input int r, input int w,
                                input int b, input int c, input int t);
        vec_t v;
        v.rst   = 1'(rst);
        v.ihit  = 1'(ih);
        v.dhit  = NCH'(dh);
        v.dren  = NCH'(dr);
        v.dwen  = NCH'(dw);
        v.flush = 1'(fl);
        v.pcen  = 1'(pc);
        v.ren   = NCH'(r);
        v.wen   = NCH'(w);
        v.busy  = 1'(b);
        v.cnt   = CNT_W'(c);
        v.tmo   = 1'(t);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %0h, want %0h", nm, n_vec, act, exp);
        end
    endtask

    // Drive one vector, check pcen in-cycle, then check registered outputs.
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge CLK);
        RST   = v.rst;
        ihit  = v.ihit;
        dhit  = v.dhit;
        dREN  = v.dren;
        dWEN  = v.dwen;
        flush = v.flush;
        #1;
        check("pcen", 32'(pcen), 32'(v.pcen));
        exp_q.push_back(v);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check("dmemREN",   32'(dmemREN),   32'(e.ren));
        check("dmemWEN",   32'(dmemWEN),   32'(e.wen));
        check("busy",      32'(busy),      32'(e.busy));
        check("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
        check("timeout",   32'(timeout),   32'(e.tmo));
        n_vec++;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST   = 1'b1;
        ihit  = 1'b0;
        dhit  = '0;
        dREN  = '0;
        dWEN  = '0;
        flush = 1'b0;

        //            rst ih dhit  dren  dwen  fl  pc  ren   wen   b cnt t
        // reset held with pending inputs
        tbl.push_back(mk(1, 1, 'b00, 'b11, 'b00, 0, 0, 'b00, 'b00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'b00, 'b11, 'b00, 0, 0, 'b00, 'b00, 0, 0, 0));
        // single read on ch0, three stall cycles, then hit
        tbl.push_back(mk(0, 1, 'b00, 'b01, 'b00, 0, 1, 'b01, 'b00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b01, 'b00, 1, 1, 0));
        tbl.push_back(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b01, 'b00, 1, 2, 0));
        tbl.push_back(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b01, 'b00, 1, 3, 0));
        tbl.push_back(mk(0, 1, 'b01, 'b00, 'b00, 0, 1, 'b00, 'b00, 0, 0, 0));
        // ch0 write + ch1 read, staggered hits; new ch1 request ignored
        tbl.push_back(mk(0, 1, 'b00, 'b10, 'b01, 0, 1, 'b10, 'b01, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b01, 'b00, 'b00, 0, 0, 'b10, 'b00, 1, 1, 0));
        tbl.push_back(mk(0, 1, 'b00, 'b00, 'b10, 0, 0, 'b10, 'b00, 1, 2, 0));
        tbl.push_back(mk(0, 1, 'b10, 'b00, 'b00, 0, 1, 'b00, 'b00, 0, 0, 0));
        // read+write on ch1 -> write only
        tbl.push_back(mk(0, 1, 'b00, 'b10, 'b10, 0, 1, 'b00, 'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'b10, 'b00, 'b00, 0, 0, 'b00, 'b00, 0, 0, 0));
        // dhit with ihit and a new request: completes, no relatch
        tbl.push_back(mk(0, 1, 'b00, 'b01, 'b00, 0, 1, 'b01, 'b00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'b01, 'b01, 'b00, 0, 1, 'b00, 'b00, 0, 0, 0));
        // dhit on idle channels ignored; idle dhit blocks a latch
        tbl.push_back(mk(0, 0, 'b11, 'b00, 'b00, 0, 0, 'b00, 'b00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'b01, 'b01, 'b00, 0, 1, 'b00, 'b00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Timeout: abort on the fifth pending cycle even with a partial hit.
        step(mk(0, 1, 'b00, 'b01, 'b10, 0, 1, 'b01, 'b10, 1, 0, 0));
        for (int k = 1; k <= 4; k++) begin
            step(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b01, 'b10, 1, k, 0));
        end
        step(mk(0, 0, 'b01, 'b00, 'b00, 0, 0, 'b00, 'b00, 0, 0, 1));
        // Still serviced with timeout sticky.
        step(mk(0, 1, 'b00, 'b01, 'b00, 0, 1, 'b01, 'b00, 1, 0, 1));
        step(mk(0, 0, 'b01, 'b00, 'b00, 0, 0, 'b00, 'b00, 0, 0, 1));

        // Flush while pending with timeout set; overrides ihit and new request.
        step(mk(0, 1, 'b00, 'b01, 'b00, 0, 1, 'b01, 'b00, 1, 0, 1));
        step(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b01, 'b00, 1, 1, 1));
        step(mk(0, 1, 'b00, 'b10, 'b00, 1, 0, 'b00, 'b00, 0, 0, 0));

        // Flush on the abort cycle suppresses the timeout.
        step(mk(0, 1, 'b00, 'b10, 'b00, 0, 1, 'b10, 'b00, 1, 0, 0));
        for (int k = 1; k <= 4; k++) begin
            step(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b10, 'b00, 1, k, 0));
        end
        step(mk(0, 0, 'b00, 'b00, 'b00, 1, 0, 'b00, 'b00, 0, 0, 0));

        // Both channels hit on the limit cycle: normal completion.
        step(mk(0, 1, 'b00, 'b11, 'b00, 0, 1, 'b11, 'b00, 1, 0, 0));
        for (int k = 1; k <= 4; k++) begin
            step(mk(0, 0, 'b00, 'b00, 'b00, 0, 0, 'b11, 'b00, 1, k, 0));
        end
        step(mk(0, 1, 'b11, 'b00, 'b00, 0, 1, 'b00, 'b00, 0, 0, 0));

        // Reset in the middle of a pending write.
        step(mk(0, 1, 'b00, 'b00, 'b01, 0, 1, 'b00, 'b01, 1, 0, 0));
        step(mk(1, 1, 'b00, 'b11, 'b00, 0, 0, 'b00, 'b00, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
